dram_req_queue: RTL and testbench

Request queue between user logic and the DRAM controller (`DRAMCON`). It buffers up to `DEPTH` 128-bit line read/write requests behind a valid/ready handshake. Requests are issued to `DRAMCON` one at a time, gated by `calib_done` and `D_BUSY`. Read data comes back to user logic with a one-cycle valid strobe, in request order.

---
 rtl/dram_pkg.sv | 23 ++
 rtl/dram_req_fifo.sv | 44 ++++
 rtl/dram_req_queue.sv | 173 +++++++++++++++++
 tb/tb_dram_req_queue.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_pkg.sv
// Shared definitions for the DRAM request path: line width, issue FSM state
// encoding and the request entry carried through the queue.
package dram_pkg;

   localparam int unsigned LINE_W  = 128;
   localparam int unsigned DRAM_AW = 32;

   // Issue FSM states
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_CMD    = 2'd1,
      ST_WAIT   = 2'd2,
      ST_RDWAIT = 2'd3
   } dram_state_e;

   // Request entry at the default address width
   typedef struct packed {
      logic               we;
      logic [DRAM_AW-1:0] adr;
      logic [LINE_W-1:0]  din;
   } dram_req_t;

endpackage

// File: rtl/dram_req_fifo.sv
// Generic synchronous FIFO with occupancy count.
// Ports: CLK, RST (async, active-high), push/din write side,
//        pop/dout read side (dout shows the head entry), cnt occupancy.
// Caller guarantees no push when full and no pop when empty.
module dram_req_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   cnt
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [CW-1:0]    wr_ptr;
   logic [CW-1:0]    rd_ptr;

   // Pointers carry one extra bit so full and empty are distinguishable
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + CW'(1);
         if (pop)  rd_ptr <= rd_ptr + CW'(1);
      end
   end

   // Storage
   always_ff @(posedge CLK) begin
      if (push) mem[wr_ptr[PW-1:0]] <= din;
   end

   assign dout = mem[rd_ptr[PW-1:0]];
   assign cnt  = wr_ptr - rd_ptr;

endmodule

// File: rtl/dram_req_queue.sv
// Request queue between user logic and the DRAM controller. Buffers line
// read/write requests and issues them one at a time; read data returns in
// request order with a one-cycle valid strobe.
// Ports: CLK, RST (async, active-high), calib_done;
//        user side U_REQ/U_WE/U_ADR/U_DIN/U_RDY, U_DOUT/U_DOUTVALID, U_CNT;
//        controller side D_ADR/D_DIN/D_WE/D_RE, D_BUSY/D_DOUT/D_DOUTVALID;
//        ERR sticky misalignment flag, present only when
//        DRAMQ_ALIGN_CHECK_EN is defined.
module dram_req_queue
   import dram_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = 32
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   calib_done,
   input  logic                   U_REQ,
   input  logic                   U_WE,
   input  logic [AW-1:0]          U_ADR,
   input  logic [LINE_W-1:0]      U_DIN,
   output logic                   U_RDY,
   output logic [LINE_W-1:0]      U_DOUT,
   output logic                   U_DOUTVALID,
   output logic [$clog2(DEPTH):0] U_CNT,
   output logic [AW-1:0]          D_ADR,
   output logic [LINE_W-1:0]      D_DIN,
   output logic                   D_WE,
   output logic                   D_RE,
   input  logic                   D_BUSY,
   input  logic [LINE_W-1:0]      D_DOUT,
   input  logic                   D_DOUTVALID
`ifdef DRAMQ_ALIGN_CHECK_EN
   ,
   output logic                   ERR
`endif
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic              we;
      logic [AW-1:0]     adr;
      logic [LINE_W-1:0] din;
   } entry_t;

   localparam int unsigned EW = $bits(entry_t);

   entry_t       wr_entry;
   entry_t       head;
   logic [EW-1:0] rd_vec;
   logic [CW-1:0] fifo_cnt;
   logic          push;
   logic          pop;

   dram_state_e       state_q, state_d;
   logic              rd_q, rd_d;
   logic              first_q, first_d;
   logic [AW-1:0]     adr_d;
   logic [LINE_W-1:0] din_d;
   logic              we_d;
   logic              re_d;
   logic [LINE_W-1:0] dout_d;
   logic              dvalid_d;

   // Queue side: addresses are always stored line aligned
   assign push         = U_REQ & U_RDY;
   assign wr_entry.we  = U_WE;
   assign wr_entry.adr = {U_ADR[AW-1:4], 4'h0};
   assign wr_entry.din = U_DIN;
   assign head         = entry_t'(rd_vec);
   assign U_CNT        = fifo_cnt;
   assign U_RDY        = (fifo_cnt != CW'(DEPTH));

   dram_req_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .CLK  (CLK),
      .RST  (RST),
      .push (push),
      .din  (wr_entry),
      .pop  (pop),
      .dout (rd_vec),
      .cnt  (fifo_cnt)
   );

   // Issue FSM state and registered outputs
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= ST_IDLE;
         rd_q        <= 1'b0;
         first_q     <= 1'b0;
         D_ADR       <= '0;
         D_DIN       <= '0;
         D_WE        <= 1'b0;
         D_RE        <= 1'b0;
         U_DOUT      <= '0;
         U_DOUTVALID <= 1'b0;
      end else begin
         state_q     <= state_d;
         rd_q        <= rd_d;
         first_q     <= first_d;
         D_ADR       <= adr_d;
         D_DIN       <= din_d;
         D_WE        <= we_d;
         D_RE        <= re_d;
         U_DOUT      <= dout_d;
         U_DOUTVALID <= dvalid_d;
      end
   end

   // Next state / next outputs. The first WAIT cycle never looks at D_BUSY:
   // the controller may only raise it a cycle after seeing the strobe.
   always_comb begin
      state_d  = state_q;
      rd_d     = rd_q;
      first_d  = 1'b0;
      adr_d    = D_ADR;
      din_d    = D_DIN;
      we_d     = 1'b0;
      re_d     = 1'b0;
      dout_d   = U_DOUT;
      dvalid_d = 1'b0;
      pop      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (calib_done && !D_BUSY && (fifo_cnt != '0)) begin
               pop     = 1'b1;
               adr_d   = head.adr;
               din_d   = head.din;
               we_d    = head.we;
               re_d    = !head.we;
               rd_d    = !head.we;
               state_d = ST_CMD;
            end
         end
         ST_CMD: begin
            first_d = 1'b1;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (rd_q && D_DOUTVALID) begin
               dout_d   = D_DOUT;
               dvalid_d = 1'b1;
               state_d  = ST_IDLE;
            end else if (!first_q && !D_BUSY) begin
               state_d = rd_q ? ST_RDWAIT : ST_IDLE;
            end
         end
         ST_RDWAIT: begin
            if (D_DOUTVALID) begin
               dout_d   = D_DOUT;
               dvalid_d = 1'b1;
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

`ifdef DRAMQ_ALIGN_CHECK_EN
   // Sticky flag for any accepted misaligned request
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)                                   ERR <= 1'b0;
      else if (push && (U_ADR[3:0] != 4'h0))     ERR <= 1'b1;
   end
`else
   logic unused_adr_lsb;
   assign unused_adr_lsb = ^U_ADR[3:0];
`endif

endmodule

// File: tb/tb_dram_req_queue.sv
// Scoreboard bench for dram_req_queue: stimulus pushes expected commands and
// read data into queues; a monitor compares whatever the DUT presents.
module tb_dram_req_queue;

   logic          CLK = 1'b0;
   logic          RST;
   logic          calib_done;
   logic          U_REQ;
   logic          U_WE;
   logic [31:0]   U_ADR;
   logic [127:0]  U_DIN;
   logic          U_RDY;
   logic [127:0]  U_DOUT;
   logic          U_DOUTVALID;
   logic [2:0]    U_CNT;
   logic [31:0]   D_ADR;
   logic [127:0]  D_DIN;
   logic          D_WE;
   logic          D_RE;
   logic          D_BUSY;
   logic [127:0]  D_DOUT;
   logic          D_DOUTVALID;
`ifdef DRAMQ_ALIGN_CHECK_EN
   logic          ERR;
`endif

   dram_req_queue #(.DEPTH(4), .AW(32)) dut (
      .CLK(CLK), .RST(RST), .calib_done(calib_done),
      .U_REQ(U_REQ), .U_WE(U_WE), .U_ADR(U_ADR), .U_DIN(U_DIN),
      .U_RDY(U_RDY), .U_DOUT(U_DOUT), .U_DOUTVALID(U_DOUTVALID), .U_CNT(U_CNT),
      .D_ADR(D_ADR), .D_DIN(D_DIN), .D_WE(D_WE), .D_RE(D_RE),
      .D_BUSY(D_BUSY), .D_DOUT(D_DOUT), .D_DOUTVALID(D_DOUTVALID)
`ifdef DRAMQ_ALIGN_CHECK_EN
      , .ERR(ERR)
`endif
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic         we;
      logic [31:0]  adr;
      logic [127:0] din;
   } cmd_t;

   int           checks = 0;
   int           failures = 0;
   int           cyc = 0;
   int           n_strobe = 0;
   int           last_we_cyc = -100;
   bit           ctl_auto = 1'b1;
   bit           inject_dv = 1'b0;
   bit           chk_full = 1'b0;
   bit           saw_full = 1'b0;
   cmd_t         exp_cmd[$];
   logic [127:0] exp_rd[$];
   logic [127:0] mem [logic [31:0]];

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Controller model: stores writes, answers reads after a fixed latency
   localparam int RD_LAT = 5;
   initial begin
      logic [127:0] d;
      D_DOUT = '0;
      D_DOUTVALID = 1'b0;
      forever begin
         @(negedge CLK);
         if (D_WE) mem[D_ADR] = D_DIN;
         if (inject_dv) begin
            inject_dv = 1'b0;
            D_DOUT = 128'hBAD0_BAD0;
            D_DOUTVALID = 1'b1;
            @(negedge CLK);
            D_DOUTVALID = 1'b0;
         end else if (D_RE && ctl_auto) begin
            d = mem.exists(D_ADR) ? mem[D_ADR] : '0;
            repeat (RD_LAT) @(negedge CLK);
            D_DOUT = d;
            D_DOUTVALID = 1'b1;
            @(negedge CLK);
            D_DOUTVALID = 1'b0;
         end
      end
   end

   // Monitor: compares issued commands and returned read data
   initial begin
      cmd_t c;
      logic [127:0] r;
      logic prev_we, prev_re, prev_dv;
      prev_we = 1'b0; prev_re = 1'b0; prev_dv = 1'b0;
      forever begin
         @(negedge CLK);
         if (prev_we) check("we_pulse", 128'(D_WE), 128'(1'b0));
         if (prev_re) check("re_pulse", 128'(D_RE), 128'(1'b0));
         if (prev_dv) check("dv_pulse", 128'(U_DOUTVALID), 128'(1'b0));
         if (D_WE || D_RE) begin
            n_strobe++;
            check("we_re_excl", 128'(D_WE & D_RE), 128'(1'b0));
            if (D_RE) check("re_after_we_gap", 128'((cyc - last_we_cyc) >= 3), 128'(1'b1));
            if (D_WE) last_we_cyc = cyc;
            checks++;
            if (exp_cmd.size() == 0) begin
               failures++;
               $display("FAIL cmd_unexpected: got we=%0b adr=%0h, required no command", D_WE, D_ADR);
            end else begin
               c = exp_cmd.pop_front();
               check("cmd_we", 128'(D_WE), 128'(c.we));
               check("cmd_adr", 128'(D_ADR), 128'(c.adr));
               if (c.we) check("cmd_din", D_DIN, c.din);
            end
         end
         if (U_DOUTVALID) begin
            checks++;
            if (exp_rd.size() == 0) begin
               failures++;
               $display("FAIL rd_unexpected: got U_DOUTVALID with %0h, required none", U_DOUT);
            end else begin
               r = exp_rd.pop_front();
               check("rd_data", U_DOUT, r);
            end
         end
         if (chk_full && !U_RDY) begin
            saw_full = 1'b1;
            check("rdy_low_only_full", 128'(U_CNT), 128'(3'd4));
         end
         prev_we = D_WE; prev_re = D_RE; prev_dv = U_DOUTVALID;
      end
   end

   task automatic push(input logic we, input logic [31:0] adr, input logic [127:0] din);
      int n;
      cmd_t c;
      c.we = we; c.adr = {adr[31:4], 4'h0}; c.din = din;
      U_REQ = 1'b1; U_WE = we; U_ADR = adr; U_DIN = din;
      n = 0;
      while (!U_RDY && n < 200) begin
         @(posedge CLK); #1; n++;
      end
      if (n >= 200) begin
         checks++; failures++;
         $display("FAIL push_timeout: U_RDY got 0 for 200 cycles, required 1");
      end else begin
         exp_cmd.push_back(c);
         @(posedge CLK); #1;
      end
      U_REQ = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while (!(exp_cmd.size() == 0 && exp_rd.size() == 0 && U_CNT == 3'd0 && !D_WE && !D_RE)
             && n < 500) begin
         @(negedge CLK); n++;
      end
      if (n >= 500) begin
         checks++; failures++;
         $display("FAIL %s: drain got %0d cmds/%0d reads pending, required 0", name,
                  exp_cmd.size(), exp_rd.size());
      end
      repeat (8) @(negedge CLK);
   endtask

   task automatic wait_strobe(input string name, input bit rd, output bit found);
      int n;
      n = 0; found = 1'b0;
      while (n < 40 && !found) begin
         @(negedge CLK); n++;
         if (rd ? D_RE : D_WE) found = 1'b1;
      end
      if (!found) begin
         checks++; failures++;
         $display("FAIL %s: strobe got none in 40 cycles, required one", name);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation got no finish, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit           found;
      int           s0;
      int           t_fall;
      logic [127:0] wdata;

      RST = 1'b1; calib_done = 1'b0; U_REQ = 1'b0; U_WE = 1'b0;
      U_ADR = '0; U_DIN = '0; D_BUSY = 1'b0;
      repeat (3) @(negedge CLK);
      check("rst_d_we", 128'(D_WE), 128'(1'b0));
      check("rst_d_re", 128'(D_RE), 128'(1'b0));
      check("rst_d_adr", 128'(D_ADR), 128'(0));
      check("rst_d_din", D_DIN, 128'(0));
      check("rst_u_dout", U_DOUT, 128'(0));
      check("rst_u_doutvalid", 128'(U_DOUTVALID), 128'(1'b0));
      check("rst_u_cnt", 128'(U_CNT), 128'(0));
`ifdef DRAMQ_ALIGN_CHECK_EN
      check("rst_err", 128'(ERR), 128'(1'b0));
`endif
      RST = 1'b0;
      @(posedge CLK); #1;
      check("rdy_after_reset", 128'(U_RDY), 128'(1'b1));

      // Calibration gate
      for (int i = 0; i < 4; i++) push(1'b1, 32'(i * 16), 128'h1111_0000 + 128'(i));
      check("gate_cnt_full", 128'(U_CNT), 128'(3'd4));
      check("gate_rdy_low", 128'(U_RDY), 128'(1'b0));
      s0 = n_strobe;
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         check("gate_no_strobe", 128'(D_WE | D_RE), 128'(1'b0));
      end
      calib_done = 1'b1;
      wait_drain("gate_drain");
      check("gate_strobes", 128'(n_strobe - s0), 128'(4));
      check("gate_cnt_empty", 128'(U_CNT), 128'(0));

      // Write then read the same line
      wdata = 128'h0000000C_00000008_00000004_00000000;
      push(1'b1, 32'h40, wdata);
      exp_rd.push_back(wdata);
      push(1'b0, 32'h40, 128'hDEAD);
      wait_drain("wr_rd_drain");
      check("dout_hold", U_DOUT, wdata);

      // Busy stall
      push(1'b1, 32'h80, 128'h80);
      push(1'b1, 32'h90, 128'h90);
      wait_strobe("busy_first", 1'b0, found);
      if (found) begin
         D_BUSY = 1'b1;
         s0 = n_strobe;
         repeat (10) @(negedge CLK);
         check("busy_no_issue", 128'(n_strobe - s0), 128'(0));
         check("busy_queued", 128'(U_CNT), 128'(1));
         D_BUSY = 1'b0;
         t_fall = cyc;
         wait_strobe("busy_second", 1'b0, found);
         if (found) check("busy_gap_min", 128'((cyc - t_fall) >= 2), 128'(1'b1));
      end
      D_BUSY = 1'b0;
      wait_drain("busy_drain");

      // Full / pointer wrap with concurrent draining
      chk_full = 1'b1; saw_full = 1'b0;
      s0 = n_strobe;
      for (int i = 0; i < 12; i++) push(1'b1, 32'h100 + 32'(i * 16), 128'h5000 + 128'(i));
      wait_drain("wrap_drain");
      chk_full = 1'b0;
      check("wrap_saw_full", 128'(saw_full), 128'(1'b1));
      check("wrap_strobes", 128'(n_strobe - s0), 128'(12));

      // Misaligned address is forced to the line boundary
      push(1'b1, 32'h47, 128'h47);
      wait_drain("align_drain");
`ifdef DRAMQ_ALIGN_CHECK_EN
      check("align_err_set", 128'(ERR), 128'(1'b1));
      push(1'b1, 32'h50, 128'h50);
      wait_drain("align_drain2");
      check("align_err_sticky", 128'(ERR), 128'(1'b1));
`endif

      // Async reset while a read is outstanding
      ctl_auto = 1'b0;
      push(1'b0, 32'h40, '0);
      wait_strobe("rst_read", 1'b1, found);
      if (found) begin
         repeat (4) @(negedge CLK);
         RST = 1'b1;
         #1;
         check("mid_rst_d_re", 128'(D_RE), 128'(1'b0));
         check("mid_rst_d_adr", 128'(D_ADR), 128'(0));
         check("mid_rst_u_dout", U_DOUT, 128'(0));
         check("mid_rst_u_cnt", 128'(U_CNT), 128'(0));
`ifdef DRAMQ_ALIGN_CHECK_EN
         check("mid_rst_err", 128'(ERR), 128'(1'b0));
`endif
         @(negedge CLK);
         RST = 1'b0;
         inject_dv = 1'b1;
         for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            check("late_dv_ignored", 128'(U_DOUTVALID), 128'(1'b0));
         end
         check("post_rst_rdy", 128'(U_RDY), 128'(1'b1));
         check("post_rst_no_pending", 128'(exp_cmd.size()), 128'(0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
